sha256_msg_sched: RTL and testbench
===================================

Name: sha256_msg_sched

Overview:
SHA-256 message schedule generator, the producer end of the per-round W word stream consumed by the compression pipeline.
- Accepts one 512-bit padded block through a valid/ready handshake.
- Emits W[0..NUM_ROUNDS-1], one 32-bit word per advance cycle, on the same ready-gated cadence the compression core uses.
- Expands W[16..63] on the fly from a 16-word sliding window, so no 64-word storage.

Parameters:
NUM_ROUNDS, 64, number of W words emitted per block (FIPS 180-4 fixed; other values unsupported).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
block_valid  input  1  block[511:0] holds a valid padded block
block  input  512  message block; M0 = block[511:480], M15 = block[31:0]
block_ready  output  1  block accepted this cycle when block_valid && block_ready
ready  input  1  advance enable from the downstream core; W stream steps only when high
W  output  32  current schedule word W[t]
w_valid  output  1  W/w_index are valid
w_index  output  6  round index t of the word on W
busy  output  1  block in progress (RUN or DONE)
done  output  1  one-cycle pulse after the last word has been consumed

Behaviour:
- Clock and reset: single clock clk. Synchronous active-high reset; all state updates on posedge clk.
- Reset values: state=IDLE, t=0, window all zero. Outputs: W=0, w_valid=0, w_index=0, busy=0, done=0, block_ready=1 (combinational from IDLE).
- Reset mid-block: abandons the block immediately; no done pulse; next cycle is IDLE.
- States: IDLE, RUN, DONE. Encoded in 2 bits; unused encoding goes to IDLE.
- IDLE:
  - block_ready=1, w_valid=0, W=0.
  - On block_valid: window[i] <= M_i (i = 0..15), t <= 0, go to RUN.
  - ready is ignored in IDLE.
- RUN:
  - block_ready=0, w_valid=1, busy=1.
  - W = window[0] and w_index = t, both combinational from registers.
  - If ready=1:
    - window[i] <= window[i+1] for i = 0..14.
    - window[15] <= σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^32 (the W[t+16] recurrence).
    - t <= t+1.
    - If t == NUM_ROUNDS-1, go to DONE and do not increment t.
  - If ready=0: window, t and state hold, so W and w_index stay stable.
- Word functions:
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - All additions are 32-bit wrap-around; carries are discarded.
- DONE:
  - done=1, busy=1, w_valid=0, block_ready=0.
  - Unconditionally to IDLE next cycle.
  - Earliest next acceptance is the cycle after DONE.
- Handshake:
  - block_valid while busy is ignored and not queued; the upstream source holds the block until block_ready.
  - block_valid deasserted in IDLE: stay in IDLE.
- Latency:
  - W[0] appears the cycle after acceptance.
  - With ready held high, W[t] is presented t+1 cycles after acceptance.
  - done pulses 65 cycles after acceptance; busy is high for 65 cycles.
- Expansions performed per block: 64 (the last 16 computed words are never emitted, which is harmless).

Test Plan:
- Reset values: assert reset, then release with block_valid=0 -> W=0, w_valid=0, busy=0, done=0, block_ready=1; state holds IDLE across 10 idle cycles.
- "abc" block with ready=1 (block = 0x61626380, 13 zero words, then 0x00000000, 0x00000018):
  - W[0]=0x61626380, W[1..14]=0, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000.
  - All 64 words match the bench software model.
  - done pulses exactly 65 cycles after acceptance.
- Stall: drop ready for 3 cycles while w_index=20 -> W and w_index=20 held constant for those 3 cycles. After ready returns, the stream resumes at 21 with no skipped or duplicated word; done is delayed by 3 cycles.
- Back-to-back blocks: block_valid held high with a second block during RUN -> block_ready=0 throughout. Second block is accepted the cycle after done, and its W[0] equals its M0.
- Reset mid-operation: reset asserted at w_index=40 -> next cycle IDLE, w_valid=0, no done pulse. A fresh block then produces a correct full stream.
- Wrap arithmetic: all-ones block (16 × 0xFFFFFFFF) -> each W[16..63] matches the model, confirming 32-bit modulo addition and correct ROTR/SHR amounts.

Source files
------------

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: accepts a 512-bit block, streams W[0..63] from a 16-word sliding window.
// Latency: W[0] one cycle after acceptance. The stream advances only while ready is high; done pulses after W[63] is consumed.
module sha256_msg_sched #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         block_valid,
  input  logic [511:0] block,
  output logic         block_ready,
  input  logic         ready,
  output logic [31:0]  W,
  output logic         w_valid,
  output logic [5:0]   w_index,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] win_q [16];
  logic [5:0]  t_q;
  logic [31:0] w16_d;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // W[t+16] from the window holding W[t..t+15]
  always_comb begin
    w16_d = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (block_valid) begin
            for (int i = 0; i < 16; i++) win_q[i] <= block[511-32*i -: 32];
            t_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (ready) begin
            for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
            win_q[15] <= w16_d;
            if (t_q == 6'(NUM_ROUNDS - 1)) state_q <= DONE;
            else                           t_q     <= t_q + 6'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    block_ready = (state_q == IDLE);
    w_valid     = (state_q == RUN);
    busy        = (state_q == RUN) || (state_q == DONE);
    done        = (state_q == DONE);
    W           = w_valid ? win_q[0] : 32'd0;
    w_index     = w_valid ? t_q : 6'd0;
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: randomized and directed blocks checked against a plain-array FIPS 180-4 schedule model.
module tb_sha256_msg_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         block_valid;
  logic [511:0] block;
  logic         block_ready;
  logic         ready;
  logic [31:0]  W;
  logic         w_valid;
  logic [5:0]   w_index;
  logic         busy;
  logic         done;

  sha256_msg_sched dut (
    .clk         (clk),
    .reset       (reset),
    .block_valid (block_valid),
    .block       (block),
    .block_ready (block_ready),
    .ready       (ready),
    .W           (W),
    .w_valid     (w_valid),
    .w_index     (w_index),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Whole-schedule reference: the textbook 64-entry array recurrence
  task automatic fill_model(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) exp_w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
      s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
      exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one cycle after the acceptance edge (W[0] presented)
  task automatic send_block(input logic [511:0] blk);
    block       = blk;
    block_valid = 1'b1;
    for (int i = 0; i < 200 && !block_ready; i++) step();
    n_checks++;
    if (block_ready !== 1'b1)
      $display("FAIL accept_timeout: block_ready=%b required 1", block_ready);
    else
      n_pass++;
    step();
    block_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; block_valid = 1'b0; ready = 1'b0; block = '0;
    repeat (3) step();
    reset = 1'b0;
    n_checks++;
    if (W !== 32'd0 || w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        block_ready !== 1'b1 || w_index !== 6'd0)
      $display("FAIL reset_values: W=%h w_valid=%b busy=%b done=%b block_ready=%b w_index=%0d required 0/0/0/0/1/0",
               W, w_valid, busy, done, block_ready, w_index);
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      ready = 1'($urandom_range(0, 1));
      step();
      n_checks++;
      if (block_ready !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL idle_hold c=%0d: block_ready=%b w_valid=%b busy=%b done=%b required 1/0/0/0",
                 c, block_ready, w_valid, busy, done);
      else n_pass++;
    end
  endtask

  task automatic test_abc();
    logic [511:0] blk;
    logic         zeros_ok;
    blk = {32'h61626380, 416'h0, 32'h0, 32'h00000018};
    fill_model(blk);
    ready = 1'b1;
    send_block(blk);
    for (int t = 0; t < 64; t++) begin
      n_checks++;
      if (W !== exp_w[t] || w_index !== 6'(t) || w_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL abc_word t=%0d: W=%h idx=%0d vld=%b busy=%b done=%b required W=%h idx=%0d 1/1/0",
                 t, W, w_index, w_valid, busy, done, exp_w[t], t);
      else n_pass++;
      got_w[t] = W;
      step();
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1 || w_valid !== 1'b0 || block_ready !== 1'b0)
      $display("FAIL abc_done_at_65: done=%b busy=%b w_valid=%b block_ready=%b required 1/1/0/0",
               done, busy, w_valid, block_ready);
    else n_pass++;
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || block_ready !== 1'b1)
      $display("FAIL abc_after_done: done=%b busy=%b block_ready=%b required 0/0/1", done, busy, block_ready);
    else n_pass++;
    n_checks++;
    if (got_w[0] !== 32'h61626380 || got_w[15] !== 32'h00000018)
      $display("FAIL abc_w0_w15: W0=%h W15=%h required 61626380 00000018", got_w[0], got_w[15]);
    else n_pass++;
    zeros_ok = 1'b1;
    for (int t = 1; t < 15; t++) if (got_w[t] !== 32'd0) zeros_ok = 1'b0;
    n_checks++;
    if (!zeros_ok) $display("FAIL abc_w1_w14: some of W1..W14 nonzero, W1=%h required 0", got_w[1]);
    else n_pass++;
    n_checks++;
    if (got_w[16] !== 32'h61626380 || got_w[17] !== 32'h000F0000)
      $display("FAIL abc_w16_w17: W16=%h W17=%h required 61626380 000f0000", got_w[16], got_w[17]);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [511:0] blk;
    int           cyc;
    blk = rand_block();
    fill_model(blk);
    ready = 1'b1;
    send_block(blk);
    cyc = 1;
    for (int t = 0; t < 64; t++) begin
      n_checks++;
      if (W !== exp_w[t] || w_index !== 6'(t) || w_valid !== 1'b1 || done !== 1'b0)
        $display("FAIL stall_word t=%0d cyc=%0d: W=%h idx=%0d vld=%b done=%b required W=%h idx=%0d 1/0",
                 t, cyc, W, w_index, w_valid, done, exp_w[t], t);
      else n_pass++;
      if (t == 20) begin
        ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step(); cyc++;
          n_checks++;
          if (W !== exp_w[20] || w_index !== 6'd20 || w_valid !== 1'b1)
            $display("FAIL stall_hold s=%0d: W=%h idx=%0d vld=%b required W=%h idx=20 1",
                     s, W, w_index, w_valid, exp_w[20]);
          else n_pass++;
        end
        ready = 1'b1;
      end
      step(); cyc++;
    end
    n_checks++;
    if (done !== 1'b1 || w_valid !== 1'b0)
      $display("FAIL stall_done_at_%0d: done=%b w_valid=%b required 1/0", cyc, done, w_valid);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [511:0] blk_a, blk_b;
    logic [31:0]  m0_b;
    blk_a = rand_block();
    blk_b = rand_block();
    m0_b  = blk_b[511:480];
    fill_model(blk_a);
    ready = 1'b1;
    send_block(blk_a);
    block = blk_b;
    block_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      n_checks++;
      if (W !== exp_w[t] || w_index !== 6'(t) || block_ready !== 1'b0)
        $display("FAIL b2b_word_a t=%0d: W=%h idx=%0d block_ready=%b required W=%h idx=%0d 0",
                 t, W, w_index, block_ready, exp_w[t], t);
      else n_pass++;
      step();
    end
    n_checks++;
    if (done !== 1'b1 || block_ready !== 1'b0)
      $display("FAIL b2b_done_a: done=%b block_ready=%b required 1/0", done, block_ready);
    else n_pass++;
    step();
    n_checks++;
    if (block_ready !== 1'b1 || w_valid !== 1'b0)
      $display("FAIL b2b_idle_gap: block_ready=%b w_valid=%b required 1/0", block_ready, w_valid);
    else n_pass++;
    step();
    block_valid = 1'b0;
    fill_model(blk_b);
    n_checks++;
    if (W !== m0_b || w_index !== 6'd0 || w_valid !== 1'b1)
      $display("FAIL b2b_b_w0: W=%h idx=%0d vld=%b required W=%h idx=0 1", W, w_index, w_valid, m0_b);
    else n_pass++;
    for (int t = 0; t < 64; t++) begin
      n_checks++;
      if (W !== exp_w[t] || w_index !== 6'(t))
        $display("FAIL b2b_word_b t=%0d: W=%h idx=%0d required W=%h idx=%0d", t, W, w_index, exp_w[t], t);
      else n_pass++;
      step();
    end
    n_checks++;
    if (done !== 1'b1)
      $display("FAIL b2b_done_b: done=%b required 1", done);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    logic [511:0] blk;
    logic         saw_done;
    blk = rand_block();
    fill_model(blk);
    ready = 1'b1;
    send_block(blk);
    for (int t = 0; t <= 40; t++) begin
      n_checks++;
      if (W !== exp_w[t] || w_index !== 6'(t))
        $display("FAIL rstmid_word t=%0d: W=%h idx=%0d required W=%h idx=%0d", t, W, w_index, exp_w[t], t);
      else n_pass++;
      if (t == 40) reset = 1'b1;
      step();
    end
    reset = 1'b0;
    n_checks++;
    if (w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || block_ready !== 1'b1 || W !== 32'd0)
      $display("FAIL rstmid_idle: w_valid=%b busy=%b done=%b block_ready=%b W=%h required 0/0/0/1/0",
               w_valid, busy, done, block_ready, W);
    else n_pass++;
    saw_done = 1'b0;
    for (int c = 0; c < 70; c++) begin
      if (done === 1'b1 || w_valid === 1'b1) saw_done = 1'b1;
      step();
    end
    n_checks++;
    if (saw_done !== 1'b0)
      $display("FAIL rstmid_no_done: activity seen after abandon=%b required 0", saw_done);
    else n_pass++;
    blk = rand_block();
    fill_model(blk);
    send_block(blk);
    for (int t = 0; t < 64; t++) begin
      n_checks++;
      if (W !== exp_w[t] || w_index !== 6'(t) || w_valid !== 1'b1)
        $display("FAIL rstmid_fresh t=%0d: W=%h idx=%0d vld=%b required W=%h idx=%0d 1",
                 t, W, w_index, w_valid, exp_w[t], t);
      else n_pass++;
      step();
    end
    n_checks++;
    if (done !== 1'b1)
      $display("FAIL rstmid_fresh_done: done=%b required 1", done);
    else n_pass++;
    step();
  endtask

  task automatic test_wrap();
    logic [511:0] blk;
    blk = {512{1'b1}};
    fill_model(blk);
    ready = 1'b1;
    send_block(blk);
    for (int t = 0; t < 64; t++) begin
      n_checks++;
      if (W !== exp_w[t] || w_index !== 6'(t))
        $display("FAIL wrap_word t=%0d: W=%h idx=%0d required W=%h idx=%0d", t, W, w_index, exp_w[t], t);
      else n_pass++;
      // random stalls exercise hold behaviour with carry-heavy data
      ready = 1'($urandom_range(0, 3) != 0);
      while (!ready) begin
        step();
        n_checks++;
        if (W !== exp_w[t] || w_index !== 6'(t))
          $display("FAIL wrap_hold t=%0d: W=%h idx=%0d required W=%h idx=%0d", t, W, w_index, exp_w[t], t);
        else n_pass++;
        ready = 1'($urandom_range(0, 1));
      end
      step();
    end
    n_checks++;
    if (done !== 1'b1)
      $display("FAIL wrap_done: done=%b required 1", done);
    else n_pass++;
    step();
  endtask

  initial begin
    reset       = 1'b1;
    block_valid = 1'b0;
    ready       = 1'b0;
    block       = '0;
    test_reset();
    test_abc();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
